// File: rtl/swipt_pkg.sv
// Shared SWIPT downlink constants: field encodings, start bit, default timing
// and frame-width helper. Used by both the transmit and the receive stages.
// Optional feature macro: SWIPT_TX_PARITY_EN (appends one even-parity bit).
package swipt_pkg;

    localparam logic START_BIT        = 1'b1;
    localparam int   DEF_BIT_PERIOD   = 200000;
    localparam int   DEF_GUARD_CYCLES = 400000;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_CHARGE = 2'b01,
        MODE_DATA   = 2'b10,
        MODE_CFG    = 2'b11
    } swipt_mode_e;

    typedef enum logic [1:0] {
        TYPE_CMD   = 2'b00,
        TYPE_QUERY = 2'b01,
        TYPE_ACK   = 2'b10,
        TYPE_RSV   = 2'b11
    } swipt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GUARD = 2'b10
    } tx_state_e;

`ifdef SWIPT_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // start + mode + type + payload + checksum (+ optional parity)
    function automatic int frame_w(input int payload_w, input int chk_w);
        return 5 + payload_w + chk_w + PARITY_BITS;
    endfunction

endpackage

// File: rtl/swipt_frame_tx_if.sv
// Command handshake between the command scheduler (master) and the
// downlink serialiser (slave).
interface swipt_frame_tx_if #(
    parameter int PAYLOAD_W = 8
);
    logic                 tx_valid;
    logic                 tx_ready;
    logic [1:0]           tx_mode;
    logic [1:0]           tx_type;
    logic [PAYLOAD_W-1:0] tx_payload;

    modport master (
        output tx_valid, tx_mode, tx_type, tx_payload,
        input  tx_ready
    );

    modport slave (
        input  tx_valid, tx_mode, tx_type, tx_payload,
        output tx_ready
    );
endinterface

// File: rtl/swipt_bit_timer.sv
// Loadable down-counter: load_i sets PERIOD-1, en_i counts down and holds at
// zero, tick_o flags the zero count. Shared with the receive stage.
module swipt_bit_timer
    import swipt_pkg::*;
#(
    parameter int PERIOD = DEF_BIT_PERIOD
) (
    input  logic clk,
    input  logic nrst,
    input  logic load_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int CNT_W = $clog2(PERIOD + 1);

    logic [CNT_W-1:0] cnt_q;

    // Count down from the reload value; stop at zero until reloaded.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!nrst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CNT_W'(PERIOD - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/swipt_frame_tx.sv
// SWIPT downlink serialiser: latches one command, sends
// start/mode/type/payload/checksum MSB first, each bit BIT_PERIOD cycles,
// then holds the line low for GUARD_CYCLES before pulsing done.
// swiptAlive low during a frame aborts it. Optional macro SWIPT_TX_PARITY_EN
// appends an even-parity bit after the checksum.
module swipt_frame_tx
    import swipt_pkg::*;
#(
    parameter int BIT_PERIOD   = DEF_BIT_PERIOD,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int PAYLOAD_W    = 8,
    parameter int CHK_W        = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              swiptAlive,
    swipt_frame_tx_if.slave   tx,
    output logic              dout,
    output logic              busy,
    output logic              done,
    output logic              aborted
);
    localparam int HDR_W     = 5 + PAYLOAD_W;
    localparam int FRAME_W   = frame_w(PAYLOAD_W, CHK_W);
    localparam int BIT_CNT_W = $clog2(FRAME_W);
    localparam int GUARD_W   = $clog2(GUARD_CYCLES + 1);

    tx_state_e            state_q;
    logic [FRAME_W-1:0]   shreg_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [GUARD_W-1:0]   guard_cnt_q;
    logic                 dout_q;
    logic                 tx_ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 aborted_q;

    logic [HDR_W-1:0]     hdr_d;
    logic [CHK_W-1:0]     chk_d;
    logic [FRAME_W-1:0]   frame_d;

    logic accept;
    logic last_bit;
    logic bit_tick;
    logic timer_load;
    logic timer_en;

    // Build the frame image (header, popcount checksum, optional parity) from the live command.
    always_comb begin
        // NOTE: combinational logic uses blocking assignments, and every
        // variable gets a value on every pass so no latch is inferred.
        hdr_d = {START_BIT, tx.tx_mode, tx.tx_type, tx.tx_payload};
        chk_d = '0;
        for (int i = 0; i < HDR_W; i++) begin
            chk_d = chk_d + CHK_W'(hdr_d[i]);
        end
`ifdef SWIPT_TX_PARITY_EN
        frame_d = {hdr_d, chk_d, ^{hdr_d, chk_d}};
`else
        frame_d = {hdr_d, chk_d};
`endif
    end

    // A dead link never takes a command, even if ready has not dropped yet.
    assign accept     = tx.tx_valid && tx_ready_q && swiptAlive;
    assign last_bit   = (bit_cnt_q == BIT_CNT_W'(FRAME_W - 1));
    assign timer_load = accept || ((state_q == ST_SHIFT) && bit_tick && !last_bit);
    assign timer_en   = (state_q == ST_SHIFT);

    swipt_bit_timer #(
        .PERIOD (BIT_PERIOD)
    ) u_bit_timer (
        .clk    (clk),
        .nrst   (nrst),
        .load_i (timer_load),
        .en_i   (timer_en),
        .tick_o (bit_tick)
    );

    // Frame FSM with registered line, handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            guard_cnt_q <= '0;
            dout_q      <= 1'b0;
            tx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            // Ready follows the registered state, so it rises one cycle after IDLE is re-entered.
            tx_ready_q <= (state_q == ST_IDLE) && swiptAlive && !accept;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q   <= ST_SHIFT;
                        busy_q    <= 1'b1;
                        dout_q    <= frame_d[FRAME_W-1];
                        shreg_q   <= frame_d << 1;
                        bit_cnt_q <= '0;
                    end
                end
                ST_SHIFT, ST_GUARD: begin
                    if (!swiptAlive) begin
                        // Abort takes priority over bit advance and guard expiry.
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        dout_q      <= 1'b0;
                        aborted_q   <= 1'b1;
                        bit_cnt_q   <= '0;
                        guard_cnt_q <= '0;
                    end else if (state_q == ST_SHIFT) begin
                        if (bit_tick) begin
                            if (last_bit) begin
                                state_q     <= ST_GUARD;
                                dout_q      <= 1'b0;
                                bit_cnt_q   <= '0;
                                guard_cnt_q <= GUARD_W'(GUARD_CYCLES - 1);
                            end else begin
                                dout_q    <= shreg_q[FRAME_W-1];
                                shreg_q   <= shreg_q << 1;
                                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                            end
                        end
                    end else if (guard_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        guard_cnt_q <= guard_cnt_q - GUARD_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    dout_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx.tx_ready = tx_ready_q;
    assign dout        = dout_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_swipt_frame_tx.sv
// Directed bench for swipt_frame_tx with BIT_PERIOD=4, GUARD_CYCLES=8.
// DUT a: 8-bit checksum; DUT b: 2-bit checksum for the wrap case.
// Honours SWIPT_TX_PARITY_EN when the bundle is built with it.
module tb_swipt_frame_tx;

    localparam int BP = 4;
    localparam int GC = 8;
`ifdef SWIPT_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FW_A = 21 + int'(PAR);
    localparam int FW_B = 15 + int'(PAR);

    logic clk;
    logic nrst;
    logic alive_a, alive_b;
    logic dout_a, busy_a, done_a, aborted_a;
    logic dout_b, busy_b, done_b, aborted_b;

    int vec_cnt    = 0;
    int miscompares = 0;

    swipt_frame_tx_if #(.PAYLOAD_W(8)) bus_a ();
    swipt_frame_tx_if #(.PAYLOAD_W(8)) bus_b ();

    swipt_frame_tx #(
        .BIT_PERIOD (BP), .GUARD_CYCLES (GC), .PAYLOAD_W (8), .CHK_W (8)
    ) dut_a (
        .clk (clk), .nrst (nrst), .swiptAlive (alive_a), .tx (bus_a),
        .dout (dout_a), .busy (busy_a), .done (done_a), .aborted (aborted_a)
    );

    swipt_frame_tx #(
        .BIT_PERIOD (BP), .GUARD_CYCLES (GC), .PAYLOAD_W (8), .CHK_W (2)
    ) dut_b (
        .clk (clk), .nrst (nrst), .swiptAlive (alive_b), .tx (bus_b),
        .dout (dout_b), .busy (busy_b), .done (done_b), .aborted (aborted_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] with_par(input logic [31:0] base);
        if (PAR) return {base[30:0], ^base};
        return base;
    endfunction

    function automatic logic s_dout(input int which);
        return (which == 0) ? dout_a : dout_b;
    endfunction
    function automatic logic s_busy(input int which);
        return (which == 0) ? busy_a : busy_b;
    endfunction
    function automatic logic s_done(input int which);
        return (which == 0) ? done_a : done_b;
    endfunction
    function automatic logic s_ready(input int which);
        return (which == 0) ? bus_a.tx_ready : bus_b.tx_ready;
    endfunction

    // Called just after the accept edge; returns in the done cycle.
    task automatic run_frame(input int which, input logic [31:0] exp, input int fw, input string tag);
        logic [31:0] got;
        logic        stable, rdy_low, quiet;
        int          lat;
        got = '0; stable = 1'b1; rdy_low = 1'b1; quiet = 1'b1;
        for (int i = 0; i < fw; i++) begin
            for (int j = 0; j < BP; j++) begin
                if (j == 0) got = {got[30:0], s_dout(which)};
                else if (s_dout(which) !== got[0]) stable = 1'b0;
                if (s_ready(which) !== 1'b0 || s_busy(which) !== 1'b1) rdy_low = 1'b0;
                step();
            end
        end
        check({tag, "_bits"}, got, exp);
        check({tag, "_bit_hold"}, 32'(stable), 32'd1);
        check({tag, "_shift_rdy_low"}, 32'(rdy_low), 32'd1);
        lat = fw * BP;
        while (s_done(which) !== 1'b1 && lat < fw * BP + GC + 20) begin
            if (s_dout(which) !== 1'b0 || s_busy(which) !== 1'b1 || s_ready(which) !== 1'b0)
                quiet = 1'b0;
            step();
            lat++;
        end
        check({tag, "_guard_quiet"}, 32'(quiet), 32'd1);
        check({tag, "_done_latency"}, 32'(lat), 32'(fw * BP + GC));
        check({tag, "_idle_at_done"}, {30'd0, s_busy(which), s_ready(which)}, 32'd0);
    endtask

    task automatic set_cmd_a(input logic [1:0] m, input logic [1:0] t, input logic [7:0] p);
        bus_a.tx_mode    = m;
        bus_a.tx_type    = t;
        bus_a.tx_payload = p;
    endtask

    initial begin
        logic [31:0] exp1, exp2, expb;
        logic        seen;
        exp1 = with_par(32'b1_00_01_10100101_00000110);
        exp2 = with_par(32'b1_10_11_00111100_00001000);
        expb = with_par(32'b1_11_11_11111111_01);

        nrst = 1'b0; alive_a = 1'b1; alive_b = 1'b1;
        bus_a.tx_valid = 1'b0; set_cmd_a(2'b00, 2'b01, 8'hA5);
        bus_b.tx_valid = 1'b0; bus_b.tx_mode = 2'b11; bus_b.tx_type = 2'b11; bus_b.tx_payload = 8'hFF;
        repeat (3) step();
        check("reset_outputs", {27'd0, dout_a, bus_a.tx_ready, busy_a, done_a, aborted_a}, 32'd0);

        nrst = 1'b1;
        step();
        check("ready_after_release", {30'd0, bus_a.tx_ready, bus_b.tx_ready}, 32'd3);

        // Frame 1 with valid held, then a back-to-back second command.
        bus_a.tx_valid = 1'b1;
        step();
        check("f1_start_bit", {30'd0, dout_a, busy_a}, 32'd3);
        set_cmd_a(2'b10, 2'b11, 8'h3C);
        run_frame(0, exp1, FW_A, "f1");
        step();
        check("f1_ready_rise", {30'd0, bus_a.tx_ready, done_a}, 32'd2);
        step();
        check("b2b_accept", {29'd0, busy_a, bus_a.tx_ready, dout_a}, 32'd5);
        bus_a.tx_valid = 1'b0;
        run_frame(0, exp2, FW_A, "f2");
        seen = 1'b0;
        repeat (6) begin
            step();
            if (busy_a !== 1'b0 || done_a !== 1'b0) seen = 1'b1;
        end
        check("no_dup_frame", {31'd0, seen}, 32'd0);

        // Checksum wrap on the 2-bit checksum instance.
        bus_b.tx_valid = 1'b1;
        step();
        bus_b.tx_valid = 1'b0;
        run_frame(1, expb, FW_B, "wrap");

        // Abort during SHIFT.
        set_cmd_a(2'b00, 2'b01, 8'hA5);
        bus_a.tx_valid = 1'b1;
        step();
        bus_a.tx_valid = 1'b0;
        repeat (29) step();
        check("abort_pre_dout", {31'd0, dout_a}, 32'd1);
        alive_a = 1'b0;
        step();
        check("abort_pulse", {28'd0, dout_a, busy_a, done_a, aborted_a}, 32'd1);
        step();
        check("abort_one_cycle", {30'd0, aborted_a, bus_a.tx_ready}, 32'd0);
        repeat (3) step();
        check("dead_link_not_ready", {31'd0, bus_a.tx_ready}, 32'd0);
        alive_a = 1'b1;
        step();
        check("ready_after_alive", {31'd0, bus_a.tx_ready}, 32'd1);
        seen = 1'b0;
        repeat (100) begin
            step();
            if (done_a !== 1'b0 || busy_a !== 1'b0 || aborted_a !== 1'b0) seen = 1'b1;
        end
        check("no_retry_no_done", {31'd0, seen}, 32'd0);

        // Abort on the final guard cycle beats guard expiry.
        bus_a.tx_valid = 1'b1;
        step();
        bus_a.tx_valid = 1'b0;
        repeat (FW_A * BP + GC - 1) step();
        check("guard_last_cycle", {30'd0, busy_a, done_a}, 32'd2);
        alive_a = 1'b0;
        step();
        check("abort_wins_guard", {30'd0, done_a, aborted_a}, 32'd1);
        alive_a = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            step();
            if (done_a !== 1'b0) seen = 1'b1;
        end
        check("no_late_done", {31'd0, seen}, 32'd0);

        // Reset mid-frame.
        bus_a.tx_valid = 1'b1;
        step();
        bus_a.tx_valid = 1'b0;
        repeat (16) step();
        nrst = 1'b0;
        step();
        check("midframe_reset", {27'd0, dout_a, bus_a.tx_ready, busy_a, done_a, aborted_a}, 32'd0);
        seen = 1'b0;
        repeat (2) begin
            step();
            if (done_a !== 1'b0 || aborted_a !== 1'b0) seen = 1'b1;
        end
        nrst = 1'b1;
        step();
        check("reset_no_pulses", {31'd0, seen}, 32'd0);
        check("ready_after_reset", {31'd0, bus_a.tx_ready}, 32'd1);
        bus_a.tx_valid = 1'b1;
        step();
        bus_a.tx_valid = 1'b0;
        run_frame(0, exp1, FW_A, "f3");

        // Dead link in IDLE blocks acceptance.
        step();
        alive_a = 1'b0;
        bus_a.tx_valid = 1'b1;
        step();
        check("idle_dead_not_ready", {30'd0, bus_a.tx_ready, busy_a}, 32'd0);
        seen = 1'b0;
        repeat (4) begin
            step();
            if (busy_a !== 1'b0 || bus_a.tx_ready !== 1'b0) seen = 1'b1;
        end
        check("idle_dead_no_accept", {31'd0, seen}, 32'd0);
        bus_a.tx_valid = 1'b0;
        alive_a = 1'b1;
        step();
        check("idle_alive_ready", {31'd0, bus_a.tx_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
